issue_ctrl: RTL and testbench

//  In-order issue sequencer between the instruction decoder and the execute resources
//  (single-cycle ALU, shared iterative divider, data-memory port).
//  - Accepts one decoded instruction per handshake.
//  - Tracks the single outstanding DIV in a one-entry scoreboard and stalls on RAW/WAW hazards.
//  - Blocks during memory ops and bounds each with a timeout.
//  - Arbitrates the single write-back port.

---
 rtl/isa_pkg.sv | 16 +
 rtl/issue_scoreboard.sv | 50 +++++
 rtl/issue_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_issue_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// ISA constants shared between the decoder and the issue sequencer:
// op codes, write-back source encodings and the issue FSM state type.
package isa_pkg;
  localparam logic [6:0] OP_ADD  = 7'h01;
  localparam logic [6:0] OP_SUB  = 7'h02;
  localparam logic [6:0] OP_DIV  = 7'h03;
  localparam logic [6:0] OP_ADDI = 7'h04;
  localparam logic [6:0] OP_LW   = 7'h05;
  localparam logic [6:0] OP_SW   = 7'h06;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_DIV = 2'd1;
  localparam logic [1:0] WB_MEM = 2'd2;

  typedef enum logic {S_IDLE = 1'b0, S_WAIT_MEM = 1'b1} state_t;
endpackage

// File: rtl/issue_scoreboard.sv
// One-entry scoreboard for the outstanding divide: busy flag, destination
// register, and the hazard compare against the instruction being offered.
module issue_scoreboard #(
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_i,
  input  logic [REG_W-1:0] set_rd,
  input  logic             clr_i,
  input  logic             chk_div,
  input  logic             chk_mem,
  input  logic             chk_alu,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic [REG_W-1:0] rd,
  output logic             div_busy,
  output logic [REG_W-1:0] div_rd,
  output logic             hazard
);
  logic             busy_d, busy_q;
  logic [REG_W-1:0] rd_d, rd_q;
  logic             reg_hit;

  always_comb begin
    busy_d = busy_q;
    rd_d   = rd_q;
    if (clr_i) busy_d = 1'b0;
    if (set_i) begin
      busy_d = 1'b1;
      rd_d   = set_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      rd_q   <= '0;
    end else begin
      busy_q <= busy_d;
      rd_q   <= rd_d;
    end
  end

  // x0 as a divide target never blocks ALU ops; the divider itself still does.
  assign reg_hit  = (rd_q != '0) && ((rd_q == rs1) || (rd_q == rs2) || (rd_q == rd));
  assign hazard   = busy_q && (chk_div || chk_mem || (chk_alu && reg_hit));
  assign div_busy = busy_q;
  assign div_rd   = rd_q;
endmodule

// File: rtl/issue_ctrl.sv
// In-order issue sequencer: single-cycle ALU issue, one outstanding divide,
// blocking memory ops with timeout, and the shared write-back port.
module issue_ctrl
  import isa_pkg::*;
#(
  parameter int OP_W    = 7,
  parameter int REG_W   = 5,
  parameter int MEM_TMO = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [REG_W-1:0] in_rd,
  input  logic [REG_W-1:0] in_rs1,
  input  logic [REG_W-1:0] in_rs2,
  output logic             ex_valid,
  output logic [OP_W-1:0]  ex_op,
  output logic             div_start,
  input  logic             div_done,
  output logic             mem_req,
  output logic             mem_we,
  input  logic             mem_ack,
  output logic             wb_en,
  output logic [REG_W-1:0] wb_rd,
  output logic [1:0]       wb_src,
  output logic             illegal,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int TMR_W = $clog2(MEM_TMO + 1);

  logic is_alu, is_div, is_ld, is_st, is_mem;
  logic hazard, div_busy, accept, div_wb;
  logic [REG_W-1:0] div_rd;

  state_t           state_d, state_q;
  logic [TMR_W-1:0] timer_d, timer_q;
  logic             mem_req_d, mem_req_q, mem_we_d, mem_we_q, mem_err_d, mem_err_q;
  logic [REG_W-1:0] mem_rd_d, mem_rd_q;
  logic             ex_valid_d, ex_valid_q, div_start_d, div_start_q, illegal_d, illegal_q;
  logic [OP_W-1:0]  ex_op_d, ex_op_q;
  logic             wb_en_d, wb_en_q;
  logic [REG_W-1:0] wb_rd_d, wb_rd_q;
  logic [1:0]       wb_src_d, wb_src_q;
  logic [CNT_W-1:0] stall_d, stall_q;

  assign is_alu = (in_op == OP_W'(OP_ADD)) || (in_op == OP_W'(OP_SUB)) ||
                  (in_op == OP_W'(OP_ADDI));
  assign is_div = (in_op == OP_W'(OP_DIV));
  assign is_ld  = (in_op == OP_W'(OP_LW));
  assign is_st  = (in_op == OP_W'(OP_SW));
  assign is_mem = is_ld || is_st;

  issue_scoreboard #(.REG_W(REG_W)) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_i    (accept && is_div),
    .set_rd   (in_rd),
    .clr_i    (div_done),
    .chk_div  (is_div),
    .chk_mem  (is_mem),
    .chk_alu  (is_alu),
    .rs1      (in_rs1),
    .rs2      (in_rs2),
    .rd       (in_rd),
    .div_busy (div_busy),
    .div_rd   (div_rd),
    .hazard   (hazard)
  );

  // Blocking intake during div_done keeps the divide result alone on write-back.
  assign in_ready = rst_n && (state_q == S_IDLE) && !div_done && !hazard;
  assign accept   = in_valid && in_ready;
  assign div_wb   = div_done && div_busy;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_rd_d    = mem_rd_q;
    mem_err_d   = 1'b0;
    ex_valid_d  = 1'b0;
    ex_op_d     = ex_op_q;
    div_start_d = 1'b0;
    illegal_d   = 1'b0;
    wb_en_d     = 1'b0;
    wb_rd_d     = '0;
    wb_src_d    = WB_ALU;
    stall_d     = stall_q;

    if (in_valid && !in_ready && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_alu) begin
            ex_valid_d = 1'b1;
            ex_op_d    = in_op;
            if (in_rd != '0) begin
              wb_en_d  = 1'b1;
              wb_rd_d  = in_rd;
              wb_src_d = WB_ALU;
            end
          end else if (is_div) begin
            div_start_d = 1'b1;
          end else if (is_mem) begin
            state_d   = S_WAIT_MEM;
            mem_req_d = 1'b1;
            mem_we_d  = is_st;
            mem_rd_d  = in_rd;
            timer_d   = '0;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      S_WAIT_MEM: begin
        // Ack is checked first so a same-cycle ack beats the timeout.
        if (mem_ack) begin
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
          timer_d   = '0;
          if (!mem_we_q && (mem_rd_q != '0)) begin
            wb_en_d  = 1'b1;
            wb_rd_d  = mem_rd_q;
            wb_src_d = WB_MEM;
          end
        end else if (timer_q == TMR_W'(MEM_TMO - 1)) begin
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
          mem_err_d = 1'b1;
          timer_d   = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (div_wb && (div_rd != '0)) begin
      wb_en_d  = 1'b1;
      wb_rd_d  = div_rd;
      wb_src_d = WB_DIV;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_rd_q    <= '0;
      mem_err_q   <= 1'b0;
      ex_valid_q  <= 1'b0;
      ex_op_q     <= '0;
      div_start_q <= 1'b0;
      illegal_q   <= 1'b0;
      wb_en_q     <= 1'b0;
      wb_rd_q     <= '0;
      wb_src_q    <= WB_ALU;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_rd_q    <= mem_rd_d;
      mem_err_q   <= mem_err_d;
      ex_valid_q  <= ex_valid_d;
      ex_op_q     <= ex_op_d;
      div_start_q <= div_start_d;
      illegal_q   <= illegal_d;
      wb_en_q     <= wb_en_d;
      wb_rd_q     <= wb_rd_d;
      wb_src_q    <= wb_src_d;
      stall_q     <= stall_d;
    end
  end

  assign ex_valid  = ex_valid_q;
  assign ex_op     = ex_op_q;
  assign div_start = div_start_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_err   = mem_err_q;
  assign illegal   = illegal_q;
  assign wb_en     = wb_en_q;
  assign wb_rd     = wb_rd_q;
  assign wb_src    = wb_src_q;
  assign stall_cnt = stall_q;
endmodule

// File: tb/tb_issue_ctrl.sv
// Bench for issue_ctrl: directed scenarios then random traffic, each cycle
// compared against a transaction-level reference model.
module tb_issue_ctrl;
  import isa_pkg::*;

  localparam int MEM_TMO = 255;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       in_valid = 1'b0, in_ready;
  logic [6:0] in_op = '0, ex_op;
  logic [4:0] in_rd = '0, in_rs1 = '0, in_rs2 = '0, wb_rd;
  logic       ex_valid, div_start, div_done = 1'b0, mem_req, mem_we, mem_ack = 1'b0;
  logic       wb_en, illegal, mem_err;
  logic [1:0] wb_src;
  logic [15:0] stall_cnt;

  int total = 0, bad = 0;

  // reference model state
  bit m_busy, m_mem, m_we;
  logic [4:0] m_drd, m_mrd;
  int m_wait, m_stall;
  bit e_ex, e_ds, e_ill, e_wb, e_err;
  logic [6:0] e_exop;
  logic [4:0] e_wbrd;
  logic [1:0] e_wbsrc;

  issue_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .ex_valid(ex_valid), .ex_op(ex_op),
    .div_start(div_start), .div_done(div_done), .mem_req(mem_req), .mem_we(mem_we),
    .mem_ack(mem_ack), .wb_en(wb_en), .wb_rd(wb_rd), .wb_src(wb_src), .illegal(illegal),
    .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_busy = 0; m_mem = 0; m_we = 0; m_drd = '0; m_mrd = '0; m_wait = 0; m_stall = 0;
    e_ex = 0; e_ds = 0; e_ill = 0; e_wb = 0; e_err = 0; e_exop = '0; e_wbrd = '0; e_wbsrc = '0;
  endtask

  task automatic drive(input bit v, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input bit dd, input bit ack);
    in_valid = v; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    div_done = dd; mem_ack = ack;
  endtask

  // One clock: predict from the inputs currently applied, then compare after the edge.
  task automatic step();
    bit alu, dv, mm, st, rdy, acc;
    #1;
    alu = (in_op == OP_ADD) || (in_op == OP_SUB) || (in_op == OP_ADDI);
    dv  = (in_op == OP_DIV);
    st  = (in_op == OP_SW);
    mm  = st || (in_op == OP_LW);
    rdy = !m_mem && !div_done &&
          !(m_busy && (dv || mm || (alu && m_drd != 0 &&
            (m_drd == in_rs1 || m_drd == in_rs2 || m_drd == in_rd))));
    chk("in_ready", in_ready, rdy);
    acc = in_valid && rdy;
    if (in_valid && !rdy && m_stall < 65535) m_stall++;

    e_ex = acc && alu;
    if (e_ex) e_exop = in_op;
    e_ds  = acc && dv;
    e_ill = acc && !alu && !dv && !mm;
    e_err = 0;
    e_wb  = 0;
    if (m_busy && div_done && m_drd != 0) begin
      e_wb = 1; e_wbrd = m_drd; e_wbsrc = WB_DIV;
    end else if (e_ex && in_rd != 0) begin
      e_wb = 1; e_wbrd = in_rd; e_wbsrc = WB_ALU;
    end else if (m_mem && mem_ack && !m_we && m_mrd != 0) begin
      e_wb = 1; e_wbrd = m_mrd; e_wbsrc = WB_MEM;
    end
    if (m_mem) begin
      m_wait++;
      if (mem_ack) m_mem = 0;
      else if (m_wait == MEM_TMO) begin m_mem = 0; e_err = 1; end
    end
    if (m_busy && div_done) m_busy = 0;
    if (acc && dv) begin m_busy = 1; m_drd = in_rd; end
    if (acc && mm) begin m_mem = 1; m_we = st; m_mrd = in_rd; m_wait = 0; end

    @(posedge clk); #1;
    chk("ex_valid", ex_valid, e_ex);
    if (e_ex) chk("ex_op", ex_op, e_exop);
    chk("div_start", div_start, e_ds);
    chk("illegal", illegal, e_ill);
    chk("mem_req", mem_req, m_mem);
    if (m_mem) chk("mem_we", mem_we, m_we);
    chk("mem_err", mem_err, e_err);
    chk("wb_en", wb_en, e_wb);
    if (e_wb) begin
      chk("wb_rd", wb_rd, e_wbrd);
      chk("wb_src", wb_src, e_wbsrc);
    end
    chk("stall_cnt", stall_cnt, m_stall);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ready"}, in_ready, 0);
    chk({tag, "_outs"}, {ex_valid, div_start, mem_req, mem_we, wb_en, illegal, mem_err}, 0);
    chk({tag, "_exop"}, ex_op, 0);
    chk({tag, "_wb"}, {wb_rd, wb_src}, 0);
    chk({tag, "_stall"}, stall_cnt, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, OP_ADD, 0, 0, 0, 0, 0);
      step();
    end
  endtask

  initial begin
    model_clear();
    #1;
    check_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: ALU issue with and without write-back
    drive(1, OP_ADD, 3, 1, 2, 0, 0); step();
    drive(1, OP_ADD, 0, 1, 2, 0, 0); step();
    drive(1, OP_ADDI, 4, 0, 0, 0, 0); step();
    idle(1);

    // 2: RAW on the divide destination holds the ADD until div_done
    drive(1, OP_DIV, 5, 1, 2, 0, 0); step();
    for (int i = 0; i < 3; i++) begin drive(1, OP_ADD, 6, 5, 1, 0, 0); step(); end
    drive(1, OP_ADD, 6, 5, 1, 1, 0); step();
    drive(1, OP_ADD, 6, 5, 1, 0, 0); step();
    idle(1);

    // 3: independent SUB overlaps the divide; second DIV and LW must wait
    drive(1, OP_DIV, 5, 1, 2, 0, 0); step();
    drive(1, OP_SUB, 7, 1, 2, 0, 0); step();
    drive(1, OP_DIV, 8, 1, 2, 0, 0); step();
    drive(1, OP_LW, 8, 1, 2, 0, 0); step();
    drive(0, OP_ADD, 0, 0, 0, 1, 0); step();
    drive(0, OP_ADD, 0, 0, 0, 1, 0); step();   // stray div_done ignored
    idle(1);

    // 4: LW with ack after 4 cycles, then SW (no write-back)
    drive(1, OP_LW, 9, 1, 0, 0, 0); step();
    for (int i = 0; i < 3; i++) begin drive(1, OP_ADD, 1, 1, 1, 0, 0); step(); end
    drive(0, OP_ADD, 0, 0, 0, 0, 1); step();
    drive(1, OP_SW, 9, 1, 2, 0, 0); step();
    idle(2);
    drive(0, OP_ADD, 0, 0, 0, 0, 1); step();
    idle(1);

    // unknown op, then DIV to x0 (no write-back, divider still busy)
    drive(1, 7'h7F, 3, 1, 2, 0, 0); step();
    drive(1, OP_DIV, 0, 1, 2, 0, 0); step();
    drive(1, OP_ADD, 2, 0, 0, 0, 0); step();
    drive(0, OP_ADD, 0, 0, 0, 1, 0); step();

    // 5: SW timeout, then next instruction accepted
    drive(1, OP_SW, 3, 1, 2, 0, 0); step();
    for (int i = 0; i < MEM_TMO + 2; i++) begin drive(i % 3 == 0, OP_ADD, 1, 2, 3, 0, 0); step(); end
    drive(1, OP_ADD, 10, 1, 2, 0, 0); step();

    // timeout boundary: ack on the last allowed cycle wins
    drive(1, OP_LW, 11, 1, 2, 0, 0); step();
    for (int i = 0; i < MEM_TMO - 1; i++) begin drive(0, OP_ADD, 0, 0, 0, 0, 0); step(); end
    drive(0, OP_ADD, 0, 0, 0, 0, 1); step();
    idle(1);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      logic [6:0] op;
      case ($urandom_range(0, 7))
        0: op = OP_ADD; 1: op = OP_SUB; 2: op = OP_ADDI; 3, 4: op = OP_DIV;
        5: op = OP_LW;  6: op = OP_SW;  default: op = 7'h40;
      endcase
      drive($urandom_range(0, 9) < 7, op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0);
      step();
    end

    // 6: reset with a DIV pending clears everything asynchronously
    drive(1, OP_DIV, 5, 1, 2, 0, 0); step();
    drive(1, OP_ADD, 6, 5, 0, 0, 0); step();
    #2 rst_n = 1'b0;
    #1 check_zero("mid_reset");
    @(posedge clk); #1;
    model_clear();
    in_valid = 1'b0;
    rst_n = 1'b1;
    drive(0, OP_ADD, 0, 0, 0, 1, 0); step();
    drive(1, OP_ADD, 5, 5, 5, 0, 0); step();
    idle(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
